// File: rtl/uart_rx_pkg.sv
// Shared types for the UART RX majority sampler: FSM state encoding, sample ceiling, popcount helper.
// Pure declarations; no latency or flow control of its own.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VOTE    = 2'd2,
        WAIT    = 2'd3
    } sampler_state_e;

    localparam int MAX_SAMPLES = 7;

    // Narrower sample vectors are zero-extended to MAX_SAMPLES by the caller.
    function automatic logic [2:0] popcount(input logic [MAX_SAMPLES-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_SAMPLES; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchroniser for the raw RX line; both flops reset to the idle level (1).
// Latency 2 clk; no backpressure.
module uart_rx_bit_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_majority_sampler.sv
// Majority-vote RX bit sampler around the bit midpoint; UART_RX_SYNC_EN adds a 2-flop input synchroniser.
// Vote/valid appear 1 clk after edge_count==half+R+1; no backpressure, enable=0 aborts immediately.
module uart_rx_majority_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  rx_in_i,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] edge_count_i,
    output logic                  sampled_bit_o,
    output logic                  sample_valid_o,
    output logic                  noise_flag_o,
    output logic                  cfg_err_o
);

    localparam int         CW      = PRESCALE_W + 1;
    localparam int         R       = (NUM_SAMPLES - 1) / 2;
    localparam logic [2:0] MAJ_CNT = 3'(R + 1);
    localparam logic [2:0] ALL_CNT = 3'(NUM_SAMPLES);

    if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > MAX_SAMPLES) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_num_samples
        $error("NUM_SAMPLES must be odd and in 1..7");
    end

    logic rx_s;
`ifdef UART_RX_SYNC_EN
    uart_rx_bit_sync u_bit_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_in_i),
        .q_o   (rx_s)
    );
`else
    assign rx_s = rx_in_i;
`endif

    logic [CW-1:0] edge_ext, half, win_lo, vote_idx, p_m1;
    logic          cfg_err_c, cfg_block, held, go_vote;

    assign edge_ext  = {1'b0, edge_count_i};
    assign half      = ({1'b0, prescale_i} >> 1) - CW'(1);
    assign win_lo    = half - CW'(R);
    assign vote_idx  = half + CW'(R + 1);
    assign p_m1      = {1'b0, prescale_i} - CW'(1);
    assign cfg_err_c = (prescale_i < PRESCALE_W'(2)) || (half < CW'(R)) || (vote_idx > p_m1);

    sampler_state_e         state_q, state_d;
    logic [NUM_SAMPLES-1:0] samples_q, samples_d;
    logic                   armed_q, armed_d;
    logic                   bit_q, bit_d;
    logic                   noise_q, noise_d;
    logic                   cfg_err_q;
    logic [2:0]             pc;

    // The combinational term keeps the FSM parked during the first cycle after a bad prescale appears.
    assign cfg_block = cfg_err_q | cfg_err_c;
    assign held      = !enable_i || cfg_block;
    // armed_q proves the window was entered at its first sample; late entry must wait a full period.
    assign go_vote   = (state_q == COLLECT) && armed_q && (edge_ext == vote_idx) && !held;
    assign pc        = popcount(MAX_SAMPLES'(samples_q));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (held) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = COLLECT;
                COLLECT: if (go_vote) state_d = VOTE;
                VOTE:    state_d = (edge_ext == '0) ? COLLECT : WAIT;
                WAIT:    if (edge_ext == '0) state_d = COLLECT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sample_valid_o = (state_q == VOTE);
    end

    always_comb begin
        samples_d = samples_q;
        armed_d   = armed_q;
        bit_d     = bit_q;
        noise_d   = noise_q;
        if (held || (state_q == IDLE)) begin
            samples_d = '0;
            armed_d   = 1'b0;
        end else begin
            if (edge_ext == '0) begin
                samples_d = '0;
                armed_d   = 1'b0;
            end
            for (int k = 0; k < NUM_SAMPLES; k++) begin
                if (edge_ext == win_lo + CW'(k)) samples_d[k] = rx_s;
            end
            if (edge_ext == win_lo) armed_d = 1'b1;
            if (go_vote) armed_d = 1'b0;
        end
        if (held) begin
            bit_d   = 1'b1;
            noise_d = 1'b0;
        end else if (go_vote) begin
            bit_d   = (pc >= MAJ_CNT);
            noise_d = (pc != 3'd0) && (pc != ALL_CNT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samples_q <= '0;
            armed_q   <= 1'b0;
            bit_q     <= 1'b1;
            noise_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            samples_q <= samples_d;
            armed_q   <= armed_d;
            bit_q     <= bit_d;
            noise_q   <= noise_d;
            cfg_err_q <= cfg_err_c;
        end
    end

    assign sampled_bit_o = bit_q;
    assign noise_flag_o  = noise_q;
    assign cfg_err_o     = cfg_err_q;

endmodule
